cfu_crc_pipe: RTL
=================

# cfu_crc_pipe

Pipelined, multi-function CRC-32 custom functional unit that sits on the core's CFU request/response port. It accepts up to one request per cycle and keeps up to DEPTH requests in flight. Responses return in order through an internal response FIFO, so the core can issue back-to-back CRC word, halfword and byte updates without waiting for each response.

## Interface
- DEPTH, 4: maximum requests in flight (pipeline stage plus response FIFO); minimum 1.
- ID_W, 4: width of request/response ID.
- POLY, 32'hEDB88320: reflected CRC-32 polynomial used by every function.
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request valid.
- req_ready  out  1  request can be accepted this cycle.
- req_id  in  ID_W  request tag, returned unchanged.
- req_funct  in  3  function select.
- req_data0  in  32  data operand.
- req_data1  in  32  CRC seed (running CRC).
- resp_valid  out  1  response valid.
- resp_ready  in  1  consumer accepts response.
- resp_id  out  ID_W  tag of the returned request.
- resp_status  out  3  0 = OK, 1 = illegal funct.
- resp_data  out  32  updated CRC.

## Operation
- Accept occurs when req_valid & req_ready at a clock edge. Response handshake occurs when resp_valid & resp_ready.
- Functions (LSB-first, reflected, no init or final XOR inside the unit):
  - 0: update seed req_data1 with the 32 bits of req_data0.
  - 1: update with req_data0[15:0].
  - 2: update with req_data0[7:0].
  - 3..7: resp_status=1, resp_data=0, ID returned. The slot is consumed like a normal request.
- Each bit step: fb = crc[0] ^ d[i]; crc = (crc >> 1) ^ (fb ? POLY : 0), for i = 0 upward.
- Stage register: on accept, captures {id, status, result}. The result is computed combinationally from the request operands. The stage sets valid.
- Response FIFO: DEPTH entries with wrap-around read/write pointers. The stage entry is written in the cycle after capture.
- Occupancy counter `occ` counts stage valid plus FIFO entries, range 0..DEPTH.
  - Increments on accept.
  - Decrements on response handshake.
  - Unchanged when both happen in the same cycle.
- req_ready = (occ < DEPTH). This credit scheme makes FIFO overflow impossible.
- resp_valid = FIFO not empty. resp_id, resp_status and resp_data present the FIFO head and are forced to 0 while resp_valid=0.
- Order is strict: responses leave in accept order.
- Reset (async, any time): clears stage valid, FIFO pointers and occ. All in-flight requests are dropped.
  - Reset values: req_ready=1, resp_valid=0, resp_id=0, resp_status=0, resp_data=0.

## Timing
- Latency: a request accepted at edge N gives resp_valid=1 during the cycle after edge N+1 (2 cycles), provided the FIFO was empty.
- Throughput: 1 request per cycle while occ < DEPTH.
  - With DEPTH=1 and resp_ready held at 1, throughput is 1 request per 2 cycles.
  - With DEPTH>=2 and resp_ready held at 1, throughput is 1 request per cycle.
- Full: occ==DEPTH drops req_ready combinationally. A response handshake in the same cycle does not raise req_ready in that cycle; req_ready rises the cycle after, since it is derived from registered occ.
- Empty: resp_valid=0 and outputs are zero. resp_ready is ignored.
- The response payload is stable while resp_valid=1 and resp_ready=0.
- The req_* inputs are only sampled at accept.
- Pointer wrap: with DEPTH not a power of two, pointers wrap from DEPTH-1 to 0.

## Test plan
- Reset: assert rst mid-stream with 3 requests in flight -> immediately resp_valid=0, req_ready=1, outputs 0; no stale response after release.
- Known vector, chained through three requests:
  - funct 0, data0=0x34333231, data1=0xFFFFFFFF, id 1;
  - then funct 0, data0=0x38373635, data1=previous result;
  - then funct 2, data0=0x39, data1=previous result;
  - -> final resp_data=0x340BC6D9 (inverted 0xCBF43926); ids 1, 2, 3 in order; each result valid 2 cycles after its accept.
- Zero/linearity: funct 0, 1 and 2 with data0=0 and data1=0 -> resp_data=0, status 0.
- Illegal funct 5, id 7 -> resp_status=1, resp_data=0, resp_id=7, occupies one slot.
- Backpressure, DEPTH=4:
  - resp_ready=0, drive 6 requests -> exactly 4 accepted and req_ready=0;
  - release resp_ready -> 4 responses in order, then the remaining 2 accepted and returned;
  - ID order preserved across FIFO wrap.
- Simultaneous accept and response at occ==DEPTH-1 with resp_ready=1 continuously over 20 back-to-back requests -> occ constant, 1 response per cycle, no drops.

Source files
------------

// File: rtl/cfu_crc_pipe.sv
// Pipelined CRC-32 custom functional unit: one request per cycle in, in-order
// responses out through a credit-protected response FIFO.
module cfu_crc_pipe #(
  parameter int          DEPTH = 4,
  parameter int          ID_W  = 4,
  parameter logic [31:0] POLY  = 32'hEDB88320
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [ID_W-1:0] req_id,
  input  logic [2:0]      req_funct,
  input  logic [31:0]     req_data0,
  input  logic [31:0]     req_data1,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [ID_W-1:0] resp_id,
  output logic [2:0]      resp_status,
  output logic [31:0]     resp_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OW = $clog2(DEPTH + 1);
  localparam logic [OW-1:0] DEPTH_C = OW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  function automatic logic [31:0] crc_update(input logic [31:0] seed,
                                             input logic [31:0] d,
                                             input int          nbits);
    logic [31:0] c;
    logic        fb;
    c = seed;
    for (int i = 0; i < 32; i++) begin
      if (i < nbits) begin
        fb = c[0] ^ d[i];
        c  = (c >> 1) ^ (fb ? POLY : 32'h0);
      end
    end
    return c;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + PW'(1);
  endfunction

  logic [OW-1:0]   occ;
  logic [OW-1:0]   fifo_cnt;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic            accept;
  logic            pop;
  logic [2:0]      status_p0;
  logic [31:0]     data_p0;
  logic            vld_p1;
  logic [ID_W-1:0] id_p1;
  logic [2:0]      status_p1;
  logic [31:0]     data_p1;
  logic [ID_W-1:0] mem_id     [DEPTH];
  logic [2:0]      mem_status [DEPTH];
  logic [31:0]     mem_data   [DEPTH];

  assign req_ready  = (occ < DEPTH_C);
  assign resp_valid = (fifo_cnt != '0);
  assign accept     = req_valid & req_ready;
  assign pop        = resp_valid & resp_ready;

  // p0: combinational CRC of the request operands
  always_comb begin
    status_p0 = 3'd0;
    data_p0   = 32'h0;
    case (req_funct)
      3'd0:    data_p0 = crc_update(req_data1, req_data0, 32);
      3'd1:    data_p0 = crc_update(req_data1, req_data0, 16);
      3'd2:    data_p0 = crc_update(req_data1, req_data0, 8);
      default: status_p0 = 3'd1;
    endcase
  end

  // p1: stage register, captured on accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vld_p1 <= 1'b0;
    else     vld_p1 <= accept;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      id_p1     <= req_id;
      status_p1 <= status_p0;
      data_p1   <= data_p0;
    end
  end

  // p2: response FIFO; the occupancy credit guarantees a free slot on write
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      mem_id[wr_ptr]     <= id_p1;
      mem_status[wr_ptr] <= status_p1;
      mem_data[wr_ptr]   <= data_p1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      occ      <= '0;
    end else begin
      if (vld_p1) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)    rd_ptr <= ptr_inc(rd_ptr);
      case ({vld_p1, pop})
        2'b10:   fifo_cnt <= fifo_cnt + OW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   occ <= occ + OW'(1);
        2'b01:   occ <= occ - OW'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign resp_id     = resp_valid ? mem_id[rd_ptr]     : '0;
  assign resp_status = resp_valid ? mem_status[rd_ptr] : 3'd0;
  assign resp_data   = resp_valid ? mem_data[rd_ptr]   : 32'h0;

endmodule
